// File: rtl/btn_step_pulser.sv
`default_nettype none
// ============================================================================
// Module   : btn_step_pulser
// Purpose  : Converts a debounced push-button level into single-cycle command
//            pulses. One pulse is issued on press. If the button stays held,
//            a first auto-repeat follows after a hold delay, then further
//            repeats at a fixed rate. Also reports hold status and keeps a
//            wrapping count of issued pulses for debug display.
// Revision : 1.0 - initial release
// ============================================================================
module btn_step_pulser #(
    parameter int HOLD_CYCLES   = 50000000,  // press pulse to first repeat (>= 2)
    parameter int REPEAT_CYCLES = 10000000,  // spacing of repeat pulses (>= 2)
    parameter int CNT_W         = 26         // holds max(HOLD,REPEAT)-1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic       repeat_en,
    output logic       pulse,
    output logic       held,
    output logic [7:0] pulse_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             pulse_q,     pulse_d;
    logic             held_q,      held_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;

    // Next-state logic: release always wins over any terminal count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (level) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DELAY;
                end
            end

            ST_DELAY: begin
                if (!level) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    // Terminal count is parked here until repeats are allowed.
                    if (repeat_en) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_REPEAT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_REPEAT: begin
                if (!level) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!repeat_en) begin
                    // Re-enabling restarts the full repeat interval.
                    cnt_d = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d      = (state_d != ST_IDLE);
        pulse_cnt_d = pulse_d ? (pulse_cnt_q + 8'd1) : pulse_cnt_q;
    end

    // State and output registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            held_q      <= 1'b0;
            pulse_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            held_q      <= held_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign pulse     = pulse_q;
    assign held      = held_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule
`default_nettype wire
